// File: rtl/bitslice_sbox_seq.sv
// bitslice_sbox_seq
//   Word-serial bitsliced S-box layer. A state of NWORDS words (WORD_W bits
//   each) is transformed one word per cycle through a single shared
//   XOR / AND-NOT unit.
//     mode = 0 : full Ascon-style S-box (PRE, chi, POST, INV)
//     mode = 1 : chi only (Keccak-style)
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous, active-high reset
//   in_valid   din/mode valid from the upstream stage
//   in_ready   block can accept (IDLE only, low while reset is asserted)
//   din        input state, word j = din[j*WORD_W +: WORD_W]
//   mode       0 = full S-box, 1 = chi-only; latched on accept
//   busy       high in any compute state
//   out_valid  dout holds a finished result
//   out_ready  downstream accepts dout
//   dout       result state (registered, driven straight from the x register)

module bitslice_sbox_seq #(
  parameter  int NWORDS  = 5,
  parameter  int WORD_W  = 64,
  localparam int STATE_W = NWORDS * WORD_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [STATE_W-1:0] din,
  input  logic               mode,
  output logic               busy,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [STATE_W-1:0] dout
);

  localparam int MID = (NWORDS - 1) / 2;
  localparam int CW  = $clog2(NWORDS) + 1;
  localparam int IW  = $clog2(NWORDS);

  generate
    if ((NWORDS % 2) == 0 || NWORDS < 3 || NWORDS > 15) begin : g_bad_nwords
      $error("bitslice_sbox_seq: NWORDS must be odd and within 3..15");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_CHI_T,
    S_CHI_X,
    S_POST,
    S_INV,
    S_HOLD
  } state_e;

  state_e              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                mode_q, mode_d;
  logic [WORD_W-1:0]   x_q [NWORDS];
  logic [WORD_W-1:0]   x_d [NWORDS];
  logic [WORD_W-1:0]   t_q [NWORDS];
  logic [WORD_W-1:0]   t_d [NWORDS];
  logic [WORD_W-1:0]   din_w [NWORDS];

  // Shared datapath operands and result
  logic [WORD_W-1:0]   op_a, op_b, unit_res;
  logic                use_andn;
  logic                wr_x, wr_t;
  logic [IW-1:0]       dst;
  logic                last_half, last_full;
  int                  k;

  // Index arithmetic is modulo NWORDS; the only negative argument is -1.
  function automatic logic [IW-1:0] wrap_idx(input int v);
    int r;
    r = v % NWORDS;
    if (r < 0) r = r + NWORDS;
    return IW'(r);
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < NWORDS; gi++) begin : g_words
      assign din_w[gi]                   = din[gi*WORD_W +: WORD_W];
      assign dout[gi*WORD_W +: WORD_W]   = x_q[gi];
    end
  endgenerate

  assign in_ready  = (state_q == S_IDLE) && !reset;
  assign out_valid = (state_q == S_HOLD);
  assign busy      = (state_q != S_IDLE) && (state_q != S_HOLD);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mode_d    = mode_q;
    x_d       = x_q;
    t_d       = t_q;
    op_a      = '0;
    op_b      = '0;
    use_andn  = 1'b0;
    wr_x      = 1'b0;
    wr_t      = 1'b0;
    dst       = '0;
    k         = int'(cnt_q);
    last_half = (cnt_q == CW'(MID));
    last_full = (cnt_q == CW'(NWORDS - 1));

    case (state_q)
      S_IDLE: begin
        if (in_valid && in_ready) begin
          x_d     = din_w;
          mode_d  = mode;
          cnt_d   = '0;
          state_d = mode ? S_CHI_T : S_PRE;
        end
      end
      S_PRE: begin
        // x[2k] ^= x[2k-1]; ascending k never reads an already-updated word
        dst  = wrap_idx(2 * k);
        op_a = x_q[dst];
        op_b = x_q[wrap_idx(2 * k - 1)];
        wr_x = 1'b1;
        if (last_half) begin
          cnt_d   = '0;
          state_d = S_CHI_T;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_CHI_T: begin
        // t[j] = ~x[j] & x[j+1]; x is untouched so chi stays simultaneous
        dst      = wrap_idx(k);
        op_a     = x_q[dst];
        op_b     = x_q[wrap_idx(k + 1)];
        use_andn = 1'b1;
        wr_t     = 1'b1;
        if (last_full) begin
          cnt_d   = '0;
          state_d = S_CHI_X;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_CHI_X: begin
        dst  = wrap_idx(k);
        op_a = x_q[dst];
        op_b = t_q[wrap_idx(k + 1)];
        wr_x = 1'b1;
        if (last_full) begin
          cnt_d   = '0;
          state_d = mode_q ? S_HOLD : S_POST;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_POST: begin
        // x[2k+1] ^= x[2k]; final step wraps to x[0] ^= x[NWORDS-1]
        dst  = wrap_idx(2 * k + 1);
        op_a = x_q[dst];
        op_b = x_q[wrap_idx(2 * k)];
        wr_x = 1'b1;
        if (last_half) begin
          cnt_d   = '0;
          state_d = S_INV;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_INV: begin
        // XOR with all ones = invert
        dst     = IW'(MID);
        op_a    = x_q[dst];
        op_b    = '1;
        wr_x    = 1'b1;
        state_d = S_HOLD;
      end
      S_HOLD: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    unit_res = use_andn ? (~op_a & op_b) : (op_a ^ op_b);
    if (wr_x) x_d[dst] = unit_res;
    if (wr_t) t_d[dst] = unit_res;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      mode_q  <= 1'b0;
      for (int i = 0; i < NWORDS; i++) begin
        x_q[i] <= '0;
        t_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      x_q     <= x_d;
      t_q     <= t_d;
    end
  end

endmodule

// File: tb/tb_bitslice_sbox_seq.sv
module tb_bitslice_sbox_seq;

  localparam logic [63:0] ONES = {64{1'b1}};
  localparam logic [63:0] ZW   = 64'h0;

  logic clk;
  int   cyc;
  int   n_cmp;
  int   n_bad;

  // NWORDS = 5 instance
  logic         reset5, in_valid5, in_ready5, mode5, busy5, out_valid5, out_ready5;
  logic [319:0] din5, dout5;
  // NWORDS = 3 instance
  logic         reset3, in_valid3, in_ready3, mode3, busy3, out_valid3, out_ready3;
  logic [191:0] din3, dout3;

  typedef struct {
    logic [319:0] data;
    int           lat;
    int           id;
  } exp_t;

  exp_t q5[$];
  exp_t q3[$];
  int   acc5, acc3;
  logic prev5, prev3;
  int   txn_id;

  bitslice_sbox_seq #(.NWORDS(5), .WORD_W(64)) u_dut5 (
    .clk(clk), .reset(reset5), .in_valid(in_valid5), .in_ready(in_ready5),
    .din(din5), .mode(mode5), .busy(busy5), .out_valid(out_valid5),
    .out_ready(out_ready5), .dout(dout5)
  );

  bitslice_sbox_seq #(.NWORDS(3), .WORD_W(64)) u_dut3 (
    .clk(clk), .reset(reset3), .in_valid(in_valid3), .in_ready(in_ready3),
    .din(din3), .mode(mode3), .busy(busy3), .out_valid(out_valid3),
    .out_ready(out_ready3), .dout(dout3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [319:0] act, input logic [319:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Ascon 5-bit S-box, x0 is the MSB of the 5-bit value
  function automatic logic [4:0] sbox(input logic [4:0] v);
    case (v)
      5'h00: sbox = 5'h04; 5'h01: sbox = 5'h0b; 5'h02: sbox = 5'h1f; 5'h03: sbox = 5'h14;
      5'h04: sbox = 5'h1a; 5'h05: sbox = 5'h15; 5'h06: sbox = 5'h09; 5'h07: sbox = 5'h02;
      5'h08: sbox = 5'h1b; 5'h09: sbox = 5'h05; 5'h0a: sbox = 5'h08; 5'h0b: sbox = 5'h12;
      5'h0c: sbox = 5'h1d; 5'h0d: sbox = 5'h03; 5'h0e: sbox = 5'h06; 5'h0f: sbox = 5'h1c;
      5'h10: sbox = 5'h1e; 5'h11: sbox = 5'h13; 5'h12: sbox = 5'h07; 5'h13: sbox = 5'h0e;
      5'h14: sbox = 5'h00; 5'h15: sbox = 5'h0d; 5'h16: sbox = 5'h11; 5'h17: sbox = 5'h18;
      5'h18: sbox = 5'h10; 5'h19: sbox = 5'h0c; 5'h1a: sbox = 5'h01; 5'h1b: sbox = 5'h19;
      5'h1c: sbox = 5'h16; 5'h1d: sbox = 5'h0a; 5'h1e: sbox = 5'h0f; default: sbox = 5'h17;
    endcase
  endfunction

  function automatic logic [319:0] ascon_ref(input logic [319:0] d);
    logic [319:0] r;
    logic [4:0]   v, s;
    r = '0;
    for (int b = 0; b < 64; b++) begin
      v = {d[b], d[64+b], d[128+b], d[192+b], d[256+b]};
      s = sbox(v);
      for (int j = 0; j < 5; j++) r[j*64+b] = s[4-j];
    end
    return r;
  endfunction

  function automatic logic [319:0] chi_ref(input logic [319:0] d);
    logic [63:0]  a [5];
    logic [319:0] r;
    for (int j = 0; j < 5; j++) a[j] = d[j*64 +: 64];
    for (int j = 0; j < 5; j++) r[j*64 +: 64] = a[j] ^ (~a[(j+1)%5] & a[(j+2)%5]);
    return r;
  endfunction

  // Lane b of the state carries the 5-bit input value b mod 32
  function automatic logic [319:0] lane_pat();
    logic [319:0] r;
    logic [4:0]   v;
    r = '0;
    for (int b = 0; b < 64; b++) begin
      v = 5'(b % 32);
      for (int j = 0; j < 5; j++) r[j*64+b] = v[4-j];
    end
    return r;
  endfunction

  function automatic logic [319:0] rand_state();
    logic [319:0] r;
    for (int i = 0; i < 10; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Monitors: latency on the rising edge of out_valid, data on handshake
  always @(negedge clk) begin
    if (reset5) begin
      prev5 = 1'b0;
    end else begin
      if (out_valid5 && !prev5) begin
        if (q5.size() == 0) chk("n5_spurious_out_valid", 320'(out_valid5), 320'(0));
        else chk($sformatf("n5_lat_txn%0d", q5[0].id), 320'(cyc - acc5), 320'(q5[0].lat));
      end
      if (out_valid5 && out_ready5 && q5.size() != 0) begin
        exp_t e;
        e = q5.pop_front();
        chk($sformatf("n5_dout_txn%0d", e.id), dout5, e.data);
        $display("txn%0d N=5 done at cycle %0d dout=%h", e.id, cyc, dout5);
      end
      prev5 = out_valid5;
    end
  end

  always @(negedge clk) begin
    if (reset3) begin
      prev3 = 1'b0;
    end else begin
      if (out_valid3 && !prev3) begin
        if (q3.size() == 0) chk("n3_spurious_out_valid", 320'(out_valid3), 320'(0));
        else chk($sformatf("n3_lat_txn%0d", q3[0].id), 320'(cyc - acc3), 320'(q3[0].lat));
      end
      if (out_valid3 && out_ready3 && q3.size() != 0) begin
        exp_t e;
        e = q3.pop_front();
        chk($sformatf("n3_dout_txn%0d", e.id), 320'(dout3), e.data);
        $display("txn%0d N=3 done at cycle %0d dout=%h", e.id, cyc, dout3);
      end
      prev3 = out_valid3;
    end
  end

  task automatic send5(input logic [319:0] d, input logic m, input logic [319:0] exp,
                       input int lat, input logic push);
    int n;
    exp_t e;
    txn_id++;
    if (push) begin
      e.data = exp; e.lat = lat; e.id = txn_id;
      q5.push_back(e);
    end
    @(negedge clk);
    din5 = d; mode5 = m; in_valid5 = 1'b1;
    n = 0;
    while (!in_ready5 && n < 100) begin @(negedge clk); n++; end
    if (!in_ready5) begin
      chk("n5_accept_timeout", 320'(in_ready5), 320'(1));
      in_valid5 = 1'b0;
      return;
    end
    @(posedge clk); #1;
    acc5 = cyc;
    // Changing inputs after the accept must not disturb the transaction
    in_valid5 = 1'b0; din5 = ~d; mode5 = ~m;
  endtask

  task automatic send3(input logic [191:0] d, input logic m, input logic [191:0] exp, input int lat);
    int n;
    exp_t e;
    txn_id++;
    e.data = 320'(exp); e.lat = lat; e.id = txn_id;
    q3.push_back(e);
    @(negedge clk);
    din3 = d; mode3 = m; in_valid3 = 1'b1;
    n = 0;
    while (!in_ready3 && n < 100) begin @(negedge clk); n++; end
    if (!in_ready3) begin
      chk("n3_accept_timeout", 320'(in_ready3), 320'(1));
      in_valid3 = 1'b0;
      return;
    end
    @(posedge clk); #1;
    acc3 = cyc;
    in_valid3 = 1'b0; din3 = ~d; mode3 = ~m;
  endtask

  task automatic drain5();
    int n;
    n = 0;
    while (q5.size() != 0 && n < 300) begin @(negedge clk); n++; end
    if (q5.size() != 0) begin
      chk("n5_drain_timeout", 320'(q5.size()), 320'(0));
      q5.delete();
    end
  endtask

  task automatic drain3();
    int n;
    n = 0;
    while (q3.size() != 0 && n < 300) begin @(negedge clk); n++; end
    if (q3.size() != 0) begin
      chk("n3_drain_timeout", 320'(q3.size()), 320'(0));
      q3.delete();
    end
  endtask

  logic [319:0] e_zero, e_one, e_chi_one, d_one, d_lane, d_rnd, e_bp;
  int n;

  initial begin
    n_cmp = 0; n_bad = 0; txn_id = 0; acc5 = 0; acc3 = 0;
    prev5 = 1'b0; prev3 = 1'b0;
    reset5 = 1'b1; reset3 = 1'b1;
    in_valid5 = 1'b0; din5 = '0; mode5 = 1'b0; out_ready5 = 1'b1;
    in_valid3 = 1'b0; din3 = '0; mode3 = 1'b0; out_ready3 = 1'b1;

    e_zero    = {ZW, ZW, ONES, ZW, ZW};
    d_one     = {ZW, ZW, ZW, ZW, ONES};
    e_one     = {ZW, ONES, ONES, ONES, ONES};
    e_chi_one = {ZW, ONES, ZW, ZW, ONES};

    // Reset values
    repeat (2) @(negedge clk);
    in_valid5 = 1'b1;
    @(negedge clk);
    chk("rst_in_ready_during_reset", 320'(in_ready5), 320'(0));
    chk("rst_out_valid", 320'(out_valid5), 320'(0));
    chk("rst_busy", 320'(busy5), 320'(0));
    chk("rst_dout", dout5, 320'(0));
    in_valid5 = 1'b0;
    reset5 = 1'b0; reset3 = 1'b0;
    @(negedge clk);
    chk("rst_in_ready_after", 320'(in_ready5), 320'(1));
    chk("rst_in_ready3_after", 320'(in_ready3), 320'(1));

    // Directed full-mode and chi-only vectors
    send5('0, 1'b0, e_zero, 17, 1'b1);            drain5();
    send5(d_one, 1'b0, e_one, 17, 1'b1);          drain5();
    send5(d_one, 1'b1, e_chi_one, 10, 1'b1);      drain5();
    d_lane = lane_pat();
    send5(d_lane, 1'b0, ascon_ref(d_lane), 17, 1'b1);
    send5(d_lane, 1'b1, chi_ref(d_lane), 10, 1'b1);
    for (int i = 0; i < 2; i++) begin
      d_rnd = rand_state();
      send5(d_rnd, 1'b0, ascon_ref(d_rnd), 17, 1'b1);
      d_rnd = rand_state();
      send5(d_rnd, 1'b1, chi_ref(d_rnd), 10, 1'b1);
    end
    drain5();

    // Backpressure
    out_ready5 = 1'b0;
    e_bp = ascon_ref(d_lane);
    send5(d_lane, 1'b0, e_bp, 17, 1'b1);
    n = 0;
    while (!out_valid5 && n < 100) begin @(negedge clk); n++; end
    chk("bp_out_valid_rise", 320'(out_valid5), 320'(1));
    in_valid5 = 1'b1; din5 = rand_state();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk($sformatf("bp_out_valid_c%0d", i), 320'(out_valid5), 320'(1));
      chk($sformatf("bp_dout_c%0d", i), dout5, e_bp);
      chk($sformatf("bp_in_ready_c%0d", i), 320'(in_ready5), 320'(0));
    end
    @(posedge clk); #1;
    in_valid5 = 1'b0; out_ready5 = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_in_ready_release", 320'(in_ready5), 320'(1));
    chk("bp_out_valid_release", 320'(out_valid5), 320'(0));
    drain5();

    // Reset in the middle of a full-mode run
    send5(d_lane, 1'b0, '0, 17, 1'b0);
    repeat (8) @(posedge clk);
    #2;
    chk("midrst_busy_before", 320'(busy5), 320'(1));
    reset5 = 1'b1;
    #1;
    chk("midrst_busy", 320'(busy5), 320'(0));
    chk("midrst_out_valid", 320'(out_valid5), 320'(0));
    chk("midrst_dout", dout5, 320'(0));
    chk("midrst_in_ready", 320'(in_ready5), 320'(0));
    repeat (2) @(negedge clk);
    reset5 = 1'b0;
    repeat (20) @(negedge clk);
    chk("midrst_idle_in_ready", 320'(in_ready5), 320'(1));
    chk("midrst_idle_out_valid", 320'(out_valid5), 320'(0));
    send5(d_one, 1'b0, e_one, 17, 1'b1);
    drain5();

    // NWORDS = 3 build
    send3({ZW, ZW, ONES}, 1'b0, {ZW, ONES, ONES}, 11);
    drain3();
    send3(192'(0), 1'b0, {ZW, ONES, ZW}, 11);
    drain3();

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
